// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// mem_pkg : shared access-mode codes, result-select code and FSM states
// Revision: 1.0
// ============================================================================
package mem_pkg;

    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    // Any mode that is not an explicit byte or half code behaves as a word.
    function automatic logic [1:0] access_size(input logic [2:0] mode);
        case (mode[1:0])
            2'b00:   access_size = SIZE_B;
            2'b01:   access_size = SIZE_H;
            default: access_size = SIZE_W;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_if.sv
`default_nettype none
// ============================================================================
// mem_bus_if : request/grant/response data-memory bus
// Revision: 1.0
// ============================================================================
interface mem_bus_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_be;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_align_unit.sv
`default_nettype none
// ============================================================================
// mem_align_unit : store lane/byte-enable generation, misalign detection and
//                  load shift/extend (purely combinational)
// Revision: 1.0
// ============================================================================
module mem_align_unit
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic [1:0]            addr_lo,
    input  wire logic [2:0]            mode,
    input  wire logic [DATA_WIDTH-1:0] store_data,
    output logic      [3:0]            store_be,
    output logic      [DATA_WIDTH-1:0] store_wdata,
    output logic                       misaligned,
    input  wire logic [1:0]            load_offset,
    input  wire logic [2:0]            load_mode,
    input  wire logic [DATA_WIDTH-1:0] load_word,
    output logic      [DATA_WIDTH-1:0] load_result
);

    logic [1:0]            w_store_size;
    logic [1:0]            w_load_size;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic                  w_sign;

    assign w_store_size = access_size(mode);
    assign w_load_size  = access_size(load_mode);

    always_comb begin
        store_be    = 4'b1111;
        store_wdata = store_data;
        misaligned  = 1'b0;
        case (w_store_size)
            SIZE_B: begin
                store_be    = 4'b0001 << addr_lo;
                store_wdata = {(DATA_WIDTH/8){store_data[7:0]}};
            end
            SIZE_H: begin
                store_be    = 4'b0011 << {addr_lo[1], 1'b0};
                store_wdata = {(DATA_WIDTH/16){store_data[15:0]}};
                misaligned  = addr_lo[0];
            end
            default: begin
                misaligned  = |addr_lo;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0 before extending.
    assign w_shifted = load_word >> {load_offset, 3'b000};
    assign w_sign    = ~load_mode[2];

    always_comb begin
        load_result = w_shifted;
        case (w_load_size)
            SIZE_B:  load_result = {{(DATA_WIDTH-8){w_sign & w_shifted[7]}}, w_shifted[7:0]};
            SIZE_H:  load_result = {{(DATA_WIDTH-16){w_sign & w_shifted[15]}}, w_shifted[15:0]};
            default: load_result = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// mem_access_stage : memory-stage load/store unit driving a multi-cycle
//                    request/grant/response bus and stalling the pipeline
// Revision: 1.0
// ============================================================================
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 5
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  RegWriteM,
    input  wire logic [1:0]            ResultSrcM,
    input  wire logic                  MemWriteM,
    input  wire logic [DATA_WIDTH-1:0] ALUResultM,
    input  wire logic [DATA_WIDTH-1:0] WriteDataM,
    input  wire logic [2:0]            modeBUM,
    output logic                       RegWriteMQ,
    output logic      [DATA_WIDTH-1:0] ReadDataM,
    output logic                       StallM,
    output logic                       MisalignM,
    mem_bus_if.master                  bus
);

    // Only a 32-bit, four-lane bus is supported; other builds never start an access.
    localparam logic CFG_OK = (DATA_WIDTH == 32) && (WIDTH > 0);

    mem_state_t            r_state;
    mem_state_t            w_next_state;

    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [3:0]            r_be;
    logic [1:0]            r_offset;
    logic [2:0]            r_mode;

    logic                  w_access;
    logic                  w_misaligned;
    logic                  w_start;
    logic [3:0]            w_store_be;
    logic [DATA_WIDTH-1:0] w_store_wdata;
    logic [DATA_WIDTH-1:0] w_load_result;

    mem_align_unit #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .addr_lo     (ALUResultM[1:0]),
        .mode        (modeBUM),
        .store_data  (WriteDataM),
        .store_be    (w_store_be),
        .store_wdata (w_store_wdata),
        .misaligned  (w_misaligned),
        .load_offset (r_offset),
        .load_mode   (r_mode),
        .load_word   (bus.mem_rdata),
        .load_result (w_load_result)
    );

    assign w_access = MemWriteM | (ResultSrcM == RESULT_SRC_LOAD);
    assign w_start  = w_access & ~w_misaligned & CFG_OK;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        StallM       = 1'b0;
        MisalignM    = 1'b0;
        case (r_state)
            IDLE: begin
                MisalignM = w_access & w_misaligned;
                if (w_start) begin
                    StallM       = 1'b1;
                    w_next_state = REQ;
                end
            end
            REQ: begin
                StallM = 1'b1;
                if (bus.mem_gnt) begin
                    w_next_state = r_we ? DONE : RESP;
                end
            end
            RESP: begin
                StallM = 1'b1;
                if (bus.mem_rvalid) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        if (rst) begin
            StallM    = 1'b0;
            MisalignM = 1'b0;
        end
    end

    // A misaligned access must not write its destination register.
    assign RegWriteMQ = RegWriteM & ~MisalignM;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= 4'b0000;
            r_offset  <= 2'b00;
            r_mode    <= 3'b000;
            ReadDataM <= '0;
        end else begin
            if (r_state == IDLE && w_start) begin
                r_we     <= MemWriteM;
                r_addr   <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
                r_wdata  <= MemWriteM ? w_store_wdata : '0;
                r_be     <= MemWriteM ? w_store_be : 4'b1111;
                r_offset <= ALUResultM[1:0];
                r_mode   <= modeBUM;
            end
            if (r_state == RESP && bus.mem_rvalid) begin
                ReadDataM <= w_load_result;
            end
        end
    end

    assign bus.mem_req   = (r_state == REQ);
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_be    = r_be;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_access_stage : directed self-checking bench for mem_access_stage
// Revision: 1.0
// ============================================================================
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [2:0]  modeBUM;
    logic        RegWriteMQ;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MisalignM;

    int compared;
    int mismatched;

    mem_bus_if #(.DATA_WIDTH(32)) bus ();

    mem_access_stage #(
        .DATA_WIDTH (32),
        .WIDTH      (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .MemWriteM  (MemWriteM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .modeBUM    (modeBUM),
        .RegWriteMQ (RegWriteMQ),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_nop();
        RegWriteM  = 1'b0;
        ResultSrcM = 2'b00;
        MemWriteM  = 1'b0;
        ALUResultM = 32'h0;
        WriteDataM = 32'h0;
        modeBUM    = 3'b010;
    endtask

    // One access with a behavioural slave: gnt after gnt_wait REQ cycles,
    // rvalid the cycle after gnt for loads.
    task automatic do_access(input string tag, input logic store, input logic [2:0] mode,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int gnt_wait,
                             input logic [31:0] exp_addr, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input int exp_stalls);
        int   stalls;
        int   gcnt;
        logic granted;
        logic rvp;
        logic done;
        stalls  = 0;
        gcnt    = 0;
        granted = 1'b0;
        rvp     = 1'b0;
        done    = 1'b0;
        @(negedge clk);
        RegWriteM  = ~store;
        ResultSrcM = store ? 2'b00 : 2'b01;
        MemWriteM  = store;
        ALUResultM = addr;
        WriteDataM = wdata;
        modeBUM    = mode;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (!StallM) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (c == 0) begin
                    check({tag, " regwriteq"}, {31'b0, RegWriteMQ}, {31'b0, ~store});
                    check({tag, " misalign"}, {31'b0, MisalignM}, 32'h0);
                end
                if (bus.mem_req) begin
                    check({tag, " addr"}, bus.mem_addr, exp_addr);
                    check({tag, " be"}, {28'b0, bus.mem_be}, {28'b0, exp_be});
                    check({tag, " we"}, {31'b0, bus.mem_we}, {31'b0, store});
                    if (store) check({tag, " wdata"}, bus.mem_wdata, exp_wdata);
                end
                if (rvp) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = rdata;
                    rvp            = 1'b0;
                end else if (bus.mem_req && !granted) begin
                    if (gcnt == gnt_wait) begin
                        bus.mem_gnt = 1'b1;
                        granted     = 1'b1;
                        rvp         = ~store;
                    end else begin
                        gcnt++;
                    end
                end
                @(negedge clk);
            end
        end
        drive_nop();
        check({tag, " stall cycles"}, stalls, exp_stalls);
    endtask

    initial begin
        compared       = 0;
        mismatched     = 0;
        rst            = 1'b1;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        // Misaligned LW presented during reset: no flag, no stall.
        RegWriteM  = 1'b1;
        ResultSrcM = 2'b01;
        MemWriteM  = 1'b0;
        ALUResultM = 32'h101;
        WriteDataM = 32'h0;
        modeBUM    = 3'b010;
        repeat (2) @(negedge clk);
        #1;
        check("rst stall", {31'b0, StallM}, 32'h0);
        check("rst misalign", {31'b0, MisalignM}, 32'h0);
        check("rst req", {31'b0, bus.mem_req}, 32'h0);
        check("rst we", {31'b0, bus.mem_we}, 32'h0);
        check("rst addr", bus.mem_addr, 32'h0);
        check("rst wdata", bus.mem_wdata, 32'h0);
        check("rst be", {28'b0, bus.mem_be}, 32'h0);
        check("rst rdata", ReadDataM, 32'h0);
        drive_nop();
        rst = 1'b0;

        do_access("SW", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0,
                  32'h100, 4'b1111, 32'hDEADBEEF, 2);
        @(negedge clk); #1;
        check("SW readdata kept", ReadDataM, 32'h0);

        do_access("LB", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0,
                  32'h100, 4'b1111, 32'h0, 3);
        @(negedge clk); #1;
        check("LB readdata", ReadDataM, 32'hFFFFFF80);

        do_access("LBU", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0,
                  32'h100, 4'b1111, 32'h0, 3);
        @(negedge clk); #1;
        check("LBU readdata", ReadDataM, 32'h00000080);

        do_access("SH", 1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0, 0,
                  32'h100, 4'b1100, 32'h12341234, 2);
        @(negedge clk); #1;
        check("SH readdata kept", ReadDataM, 32'h00000080);

        do_access("LHU", 1'b0, 3'b101, 32'h102, 32'h0, 32'hABCD0000, 0,
                  32'h100, 4'b1111, 32'h0, 3);
        @(negedge clk); #1;
        check("LHU readdata", ReadDataM, 32'h0000ABCD);

        // Misaligned LW: flagged, register write suppressed, no bus traffic.
        @(negedge clk);
        RegWriteM  = 1'b1;
        ResultSrcM = 2'b01;
        ALUResultM = 32'h101;
        modeBUM    = 3'b010;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("LW mis misalign", {31'b0, MisalignM}, 32'h1);
            check("LW mis regwriteq", {31'b0, RegWriteMQ}, 32'h0);
            check("LW mis stall", {31'b0, StallM}, 32'h0);
            check("LW mis req", {31'b0, bus.mem_req}, 32'h0);
            @(negedge clk);
        end
        drive_nop();
        #1;
        check("nop regwriteq", {31'b0, RegWriteMQ}, 32'h0);

        do_access("SB bp", 1'b1, 3'b000, 32'h201, 32'h0000005A, 32'h0, 3,
                  32'h200, 4'b0010, 32'h5A5A5A5A, 5);

        // Reset while waiting for the response, then a stray rvalid.
        @(negedge clk);
        RegWriteM  = 1'b1;
        ResultSrcM = 2'b01;
        ALUResultM = 32'h104;
        modeBUM    = 3'b010;
        @(negedge clk); #1;
        check("rstmid req", {31'b0, bus.mem_req}, 32'h1);
        bus.mem_gnt = 1'b1;
        @(negedge clk); #1;
        bus.mem_gnt = 1'b0;
        check("rstmid resp stall", {31'b0, StallM}, 32'h1);
        rst = 1'b1;
        drive_nop();
        #1;
        check("rstmid stall in rst", {31'b0, StallM}, 32'h0);
        @(negedge clk); #1;
        rst            = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFFFFFF;
        @(negedge clk); #1;
        bus.mem_rvalid = 1'b0;
        check("rstmid req", {31'b0, bus.mem_req}, 32'h0);
        check("rstmid stall", {31'b0, StallM}, 32'h0);
        check("rstmid readdata", ReadDataM, 32'h0);
        @(negedge clk); #1;
        check("rstmid readdata hold", ReadDataM, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
